// File: rtl/digdar_seq_pkg.sv
// Shared types and constants for the digdar capture sequencer
// and the event counters used for time-stamping.
package digdar_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_CAPTURE   = 3'd3,
        S_READY     = 3'd4,
        S_HOLDOFF   = 3'd5
    } seq_state_t;

    localparam logic [3:0] TRIG_NONE  = 4'd0;
    localparam logic [3:0] TRIG_RADAR = 4'd2;
    localparam logic [3:0] TRIG_ACP   = 4'd3;
    localparam logic [3:0] TRIG_ARP   = 4'd4;

    localparam int CLK_W   = 64;
    localparam int PULSE_W = 32;
    localparam int ACP_W   = 16;
    localparam int ARP_W   = 32;
    localparam int SKIP_W  = 16;
    localparam int HOLD_W  = 32;

    // Radar source is offered only once the skip budget is spent.
    function automatic logic [3:0] radar_gate(
        input logic [SKIP_W-1:0] skip,
        input logic [3:0]        code
    );
        return (skip == '0) ? code : TRIG_NONE;
    endfunction

endpackage

// File: rtl/digdar_capture_sequencer_if.sv
// Software-side view of the sequencer: buffer-ready metadata
// and the acknowledge that releases the buffer.
interface digdar_capture_sequencer_if #(
    parameter int OVR_W = 16
);
    import digdar_seq_pkg::*;

    logic                 meta_valid;
    logic                 sw_ack;
    logic [PULSE_W-1:0]   pulse_num;
    logic [ACP_W-1:0]     acp_cnt;
    logic [ARP_W-1:0]     arp_cnt;
    logic [CLK_W-1:0]     clk_stamp;
    logic [OVR_W-1:0]     overrun_cnt;

    modport master (
        output meta_valid, pulse_num, acp_cnt,
        output arp_cnt, clk_stamp, overrun_cnt,
        input  sw_ack
    );

    modport slave (
        input  meta_valid, pulse_num, acp_cnt,
        input  arp_cnt, clk_stamp, overrun_cnt,
        output sw_ack
    );

endinterface

// File: rtl/digdar_event_counters.sv
// Free-running clock, radar-pulse, ACP and ARP counters
// shared by digdar blocks for time-stamping.
module digdar_event_counters
    import digdar_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               radar_trig,
    input  logic               acp_trig,
    input  logic               arp_trig,
    output logic [CLK_W-1:0]   clk_cnt,
    output logic [PULSE_W-1:0] pulse_cnt,
    output logic [ACP_W-1:0]   acp_cnt,
    output logic [ARP_W-1:0]   arp_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt   <= '0;
            pulse_cnt <= '0;
            acp_cnt   <= '0;
            arp_cnt   <= '0;
        end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
            if (radar_trig)
                pulse_cnt <= pulse_cnt + PULSE_W'(1);
            if (arp_trig)
                arp_cnt <= arp_cnt + ARP_W'(1);
            // ARP marks azimuth zero, so it wins over a same-cycle ACP.
            if (arp_trig)
                acp_cnt <= '0;
            else if (acp_trig)
                acp_cnt <= acp_cnt + ACP_W'(1);
        end
    end

endmodule

// File: rtl/digdar_capture_sequencer.sv
// Autonomous arm / trigger / metadata sequencer for the scope
// capture path, running in the ADC clock domain.
module digdar_capture_sequencer
    import digdar_seq_pkg::*;
#(
    parameter logic [3:0] TRIG_SRC_RADAR = TRIG_RADAR,
    parameter int         CAP_START_TO   = 8,
    parameter int         OVR_W          = 16
) (
    input  logic               adc_clk_i,
    input  logic               adc_rstn_i,
    input  logic               radar_trig_i,
    input  logic               acp_trig_i,
    input  logic               arp_trig_i,
    input  logic               capturing_i,
    input  logic               cfg_enable_i,
    input  logic [SKIP_W-1:0]  cfg_skip_i,
    input  logic [HOLD_W-1:0]  cfg_holdoff_i,
    input  logic               sw_ack_i,
    output logic               arm_o,
    output logic [3:0]         trig_src_o,
    output logic               meta_valid_o,
    output logic [PULSE_W-1:0] pulse_num_o,
    output logic [ACP_W-1:0]   acp_cnt_o,
    output logic [ARP_W-1:0]   arp_cnt_o,
    output logic [CLK_W-1:0]   clk_stamp_o,
    output logic [OVR_W-1:0]   overrun_cnt_o,
    output logic [2:0]         state_o
);

    localparam int CAP_W = $clog2(CAP_START_TO + 1);
    localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(CAP_START_TO - 1);

    seq_state_t         state;
    logic [SKIP_W-1:0]  skip_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [CAP_W-1:0]   cap_cnt;
    logic               seen_hi;

    logic [CLK_W-1:0]   clk_cnt;
    logic [PULSE_W-1:0] pulse_cnt;
    logic [ACP_W-1:0]   acp_cnt;
    logic [ARP_W-1:0]   arp_cnt;

    digdar_event_counters u_cnt (
        .clk        (adc_clk_i),
        .rst_n      (adc_rstn_i),
        .radar_trig (radar_trig_i),
        .acp_trig   (acp_trig_i),
        .arp_trig   (arp_trig_i),
        .clk_cnt    (clk_cnt),
        .pulse_cnt  (pulse_cnt),
        .acp_cnt    (acp_cnt),
        .arp_cnt    (arp_cnt)
    );

    assign state_o = state;

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state         <= S_IDLE;
            skip_cnt      <= '0;
            hold_cnt      <= '0;
            cap_cnt       <= '0;
            seen_hi       <= 1'b0;
            arm_o         <= 1'b0;
            trig_src_o    <= TRIG_NONE;
            meta_valid_o  <= 1'b0;
            pulse_num_o   <= '0;
            acp_cnt_o     <= '0;
            arp_cnt_o     <= '0;
            clk_stamp_o   <= '0;
            overrun_cnt_o <= '0;
        end else begin
            arm_o <= 1'b0;
            // Missed pulses are counted even if READY is being left.
            if (state == S_READY && radar_trig_i &&
                overrun_cnt_o != {OVR_W{1'b1}})
                overrun_cnt_o <= overrun_cnt_o + OVR_W'(1);

            if (!cfg_enable_i) begin
                state        <= S_IDLE;
                trig_src_o   <= TRIG_NONE;
                meta_valid_o <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        state <= S_ARM;
                        arm_o <= 1'b1;
                    end
                    S_ARM: begin
                        skip_cnt   <= cfg_skip_i;
                        trig_src_o <= radar_gate(cfg_skip_i,
                                                 TRIG_SRC_RADAR);
                        state      <= S_WAIT_TRIG;
                    end
                    S_WAIT_TRIG: begin
                        if (radar_trig_i && skip_cnt == '0) begin
                            pulse_num_o <= pulse_cnt + PULSE_W'(1);
                            acp_cnt_o   <= acp_cnt;
                            arp_cnt_o   <= arp_cnt;
                            clk_stamp_o <= clk_cnt;
                            trig_src_o  <= TRIG_NONE;
                            cap_cnt     <= '0;
                            seen_hi     <= 1'b0;
                            state       <= S_CAPTURE;
                        end else if (radar_trig_i) begin
                            skip_cnt   <= skip_cnt - SKIP_W'(1);
                            trig_src_o <= radar_gate(
                                skip_cnt - SKIP_W'(1), TRIG_SRC_RADAR);
                        end
                    end
                    S_CAPTURE: begin
                        if (capturing_i) begin
                            seen_hi <= 1'b1;
                        end else if (seen_hi || cap_cnt == CAP_LAST) begin
                            meta_valid_o <= 1'b1;
                            state        <= S_READY;
                        end
                        if (!seen_hi && cap_cnt != CAP_LAST)
                            cap_cnt <= cap_cnt + CAP_W'(1);
                    end
                    S_READY: begin
                        if (sw_ack_i) begin
                            meta_valid_o <= 1'b0;
                            if (cfg_holdoff_i == '0) begin
                                state <= S_ARM;
                                arm_o <= 1'b1;
                            end else begin
                                hold_cnt <= cfg_holdoff_i;
                                state    <= S_HOLDOFF;
                            end
                        end
                    end
                    S_HOLDOFF: begin
                        if (hold_cnt <= HOLD_W'(1)) begin
                            state <= S_ARM;
                            arm_o <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/digdar_capture_sequencer.md
Name: digdar_capture_sequencer

Overview:
- Autonomous controller for the scope capture datapath. Each cycle it arms the scope and selects the radar trigger source, honouring a pulse-skip ratio.
- Latches per-capture metadata: pulse number, ACP count since the last ARP, ARP count and a 64-bit clock stamp.
- Holds the filled buffer for software until acknowledged, then waits a holdoff and re-arms.
- Sits beside the scope in the ADC clock domain; its arm and trigger-source outputs are ORed with the software bus writes.

Parameters:
- TRIG_SRC_RADAR, 4'd2, trigger-source code driven while waiting for a qualifying radar pulse.
- CAP_START_TO, 8, cycles allowed after a qualifying trigger for capturing_i to rise.
- OVR_W, 16, width of the saturating overrun counter.

Ports:
- adc_clk_i  in  1  ADC clock (only clock)
- adc_rstn_i  in  1  asynchronous, active-low reset
- radar_trig_i  in  1  one-cycle radar pulse strobe
- acp_trig_i  in  1  one-cycle ACP strobe
- arp_trig_i  in  1  one-cycle ARP strobe
- capturing_i  in  1  scope capture-active flag
- cfg_enable_i  in  1  sequencer enable
- cfg_skip_i  in  16  radar pulses to skip between captures (0 = capture every pulse)
- cfg_holdoff_i  in  32  cycles to wait after ack before re-arm
- sw_ack_i  in  1  one-cycle pulse: software finished reading the buffer
- arm_o  out  1  one-cycle arm pulse to the scope
- trig_src_o  out  4  trigger-source select to the scope
- meta_valid_o  out  1  buffer and metadata ready for software
- pulse_num_o  out  32  radar pulse number of the captured pulse
- acp_cnt_o  out  16  ACPs since last ARP at the captured pulse
- arp_cnt_o  out  32  ARP count at the captured pulse
- clk_stamp_o  out  64  free-running clock count at the captured pulse
- overrun_cnt_o  out  OVR_W  radar pulses missed while in READY, saturating
- state_o  out  3  current FSM state, for debug

Behaviour:
- Clocking and reset
  - Single clock, adc_clk_i. Reset is asynchronous and active-low on adc_rstn_i.
  - On reset every register and output is 0, and the FSM is in IDLE.
- Free-running counters (run in all states, including IDLE)
  - clk_cnt: 64-bit, increments every cycle, wraps.
  - pulse_cnt: 32-bit, increments on radar_trig_i, wraps.
  - arp_cnt: 32-bit, increments on arp_trig_i, wraps.
  - acp_cnt: 16-bit; cleared on arp_trig_i, otherwise increments on acp_trig_i and wraps. If ARP and ACP arrive in the same cycle, the result is 0.
- FSM encoding: IDLE=0, ARM=1, WAIT_TRIG=2, CAPTURE=3, READY=4, HOLDOFF=5.
- IDLE
  - trig_src_o=0.
  - Leaves for ARM when cfg_enable_i=1.
- ARM
  - arm_o=1 for exactly this one cycle.
  - skip_cnt loads cfg_skip_i.
  - Next state is WAIT_TRIG.
- WAIT_TRIG
  - trig_src_o=TRIG_SRC_RADAR only while skip_cnt==0, otherwise 0. The output is registered, so it is valid one cycle before the pulse it qualifies.
  - radar_trig_i with skip_cnt!=0: skip_cnt decrements.
  - radar_trig_i with skip_cnt==0 (qualifying pulse):
    - The next cycle latches pulse_num_o (post-increment value), acp_cnt_o, arp_cnt_o and clk_stamp_o, all taken from the trigger cycle.
    - trig_src_o goes to 0 and the FSM moves to CAPTURE.
- CAPTURE
  - Sets seen_hi when capturing_i=1.
  - Goes to READY on capturing_i=0 with seen_hi=1.
  - Also goes to READY if seen_hi is still 0 after CAP_START_TO cycles (zero-length capture).
- READY
  - meta_valid_o=1.
  - sw_ack_i clears meta_valid_o next cycle; state moves to HOLDOFF, or straight to ARM if cfg_holdoff_i==0.
  - A radar_trig_i in READY increments overrun_cnt_o, saturating at all ones. If it coincides with sw_ack_i, the counter still increments.
- HOLDOFF
  - Counts cfg_holdoff_i cycles, then moves to ARM.
  - cfg_holdoff_i is sampled on entry.
- Handshake: sw_ack_i outside READY is ignored.
- Disable: cfg_enable_i=0 in any state
  - Next state is IDLE.
  - trig_src_o=0 and meta_valid_o=0 on the next cycle.
  - Metadata outputs hold their values; overrun_cnt_o is kept.
  - A scope capture already in progress completes on its own.
- Mid-operation reset: all state is cleared asynchronously. No arm pulse is generated until cfg_enable_i is seen after release.
- Latency: arm_o to the earliest qualifying trigger is 1 cycle. Qualifying trigger to valid metadata is 1 cycle.

Decomposition:
- Package digdar_seq_pkg:
  - FSM state enum (3 bits).
  - TRIG_SRC_* codes shared with the scope: RADAR=2, ACP=3, ARP=4.
  - Counter width constants.
- Sub-module digdar_event_counters holds clk_cnt, pulse_cnt, acp_cnt and arp_cnt. It is reused by other digdar blocks for time-stamping.
- The FSM, skip counter, holdoff counter and metadata latches stay in the top module.

Test Plan:
- Reset and enable, cfg_skip_i=0:
  - One arm_o pulse 1 cycle after enable; trig_src_o=2 by the next cycle.
  - On radar_trig_i, capturing_i is driven high for 100 cycles.
  - meta_valid_o rises 1 cycle after capturing_i falls; pulse_num_o=1.
- cfg_skip_i=3, radar pulses every 50 cycles:
  - The 4th pulse is captured (pulse_num_o=4); the first three leave state_o=2.
- Counters: 5 ACPs, then ARP with ACP in the same cycle, then 2 ACPs, then a qualifying trigger:
  - acp_cnt_o=2, arp_cnt_o=1.
- Overrun: hold READY (no ack) across 3 radar pulses:
  - overrun_cnt_o=3.
  - With overrun_cnt_o preloaded to 0xFFFF, further pulses keep it at 0xFFFF.
- cfg_holdoff_i=10:
  - sw_ack_i leads to arm_o exactly 11 cycles later (10 HOLDOFF cycles plus the ARM cycle).
  - sw_ack_i pulsed in WAIT_TRIG has no effect.
- Edge cases:
  - capturing_i never rises: READY after 8 cycles.
  - cfg_enable_i dropped in CAPTURE: state_o=0 and trig_src_o=0 next cycle.
  - Asynchronous reset asserted mid-HOLDOFF: all outputs 0 immediately, with no clock edge required.
